// File: rtl/fifo_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_reader_pkg
// Description : Shared state encoding and sizing helper for the FIFO reader.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } reader_state_t;

    // Counter width able to hold every burst length from 0 to max_burst.
    function automatic int burst_count_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage : fifo_reader_pkg
`default_nettype wire

// File: rtl/reader_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : reader_skid_buffer
// Description : Two-entry in-order buffer with registered valid/data outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module reader_skid_buffer
    import fifo_reader_pkg::*;
#(
    parameter int BIT_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 push,
    input  logic [BIT_WIDTH-1:0] push_data,
    input  logic                 pop,
    output logic                 valid,
    output logic [BIT_WIDTH-1:0] data,
    output logic [1:0]           occupancy
);

    logic [BIT_WIDTH-1:0] r_head;
    logic [BIT_WIDTH-1:0] r_tail;
    logic [1:0]           r_count;
    logic                 r_valid;

    logic [BIT_WIDTH-1:0] w_head_next;
    logic [BIT_WIDTH-1:0] w_tail_next;
    logic [1:0]           w_count_next;
    logic                 w_push;
    logic                 w_pop;

    // A pop of an empty buffer or a push into a full one without a pop is dropped.
    assign w_pop  = pop && (r_count != 2'd0);
    assign w_push = push && ((r_count != 2'd2) || w_pop);

    always_comb begin
        w_head_next  = r_head;
        w_tail_next  = r_tail;
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10: begin
                if (r_count == 2'd0) begin
                    w_head_next = push_data;
                end else begin
                    w_tail_next = push_data;
                end
                w_count_next = r_count + 2'd1;
            end
            2'b01: begin
                w_head_next  = r_tail;
                w_count_next = r_count - 2'd1;
            end
            2'b11: begin
                if (r_count == 2'd1) begin
                    w_head_next = push_data;
                end else begin
                    w_head_next = r_tail;
                    w_tail_next = push_data;
                end
            end
            default: begin
                w_count_next = r_count;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
            r_valid <= 1'b0;
        end else begin
            r_head  <= w_head_next;
            r_tail  <= w_tail_next;
            r_count <= w_count_next;
            r_valid <= (w_count_next != 2'd0);
        end
    end

    assign valid     = r_valid;
    assign data      = r_head;
    assign occupancy = r_count;

endmodule : reader_skid_buffer
`default_nettype wire

// File: rtl/mixed_clock_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module      : mixed_clock_fifo_reader
// Description : Read-side burst controller draining a show-ahead FIFO into a
//               valid/ready stream, with downstream-initiated flush.
// Revision    : 1.0 - initial release
// ============================================================================
module mixed_clock_fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int BIT_WIDTH = 8,
    parameter int MAX_BURST = 15
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [BIT_WIDTH-1:0]             fifo_data_out,
    input  logic                             fifo_empty,
    output logic                             fifo_dequeue,
    output logic                             fifo_flush,
    input  logic                             burst_start,
    input  logic [$clog2(MAX_BURST+1)-1:0]   burst_length,
    input  logic                             flush_request,
    output logic [BIT_WIDTH-1:0]             data_out,
    output logic                             data_valid,
    input  logic                             data_ready,
    output logic                             busy,
    output logic                             burst_done
);

    localparam int CNT_W = burst_count_width(MAX_BURST);
    localparam logic [CNT_W-1:0] c_cnt_zero = '0;
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    reader_state_t    r_state;
    logic [CNT_W-1:0] r_fetch_remaining;
    logic [CNT_W-1:0] r_deliver_remaining;
    logic             r_fifo_flush;
    logic             r_burst_done;
    logic             r_busy;

    reader_state_t    w_state_next;
    logic [CNT_W-1:0] w_fetch_next;
    logic [CNT_W-1:0] w_deliver_next;
    logic             w_flush_next;
    logic             w_done_next;
    logic             w_dequeue;
    logic             w_transfer;
    logic [1:0]       w_occupancy;

    // Only the dequeue strobe is combinational; it must see the live empty flag.
    assign w_dequeue = (r_state == DRAIN) && !fifo_empty &&
                       (r_fetch_remaining != c_cnt_zero) &&
                       (w_occupancy < 2'd2) && !flush_request;

    // A flush discards whatever sits on the output, so it cannot count as delivered.
    assign w_transfer = data_valid && data_ready && !flush_request;

    reader_skid_buffer #(
        .BIT_WIDTH (BIT_WIDTH)
    ) u_skid (
        .clock     (clock),
        .reset     (reset),
        .clear     (flush_request),
        .push      (w_dequeue),
        .push_data (fifo_data_out),
        .pop       (w_transfer),
        .valid     (data_valid),
        .data      (data_out),
        .occupancy (w_occupancy)
    );

    always_comb begin
        w_state_next   = r_state;
        w_fetch_next   = r_fetch_remaining;
        w_deliver_next = r_deliver_remaining;
        w_flush_next   = 1'b0;
        w_done_next    = 1'b0;
        if (flush_request) begin
            w_state_next   = FLUSH;
            w_fetch_next   = c_cnt_zero;
            w_deliver_next = c_cnt_zero;
            w_flush_next   = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (burst_start) begin
                        if (burst_length == c_cnt_zero) begin
                            w_done_next = 1'b1;
                        end else begin
                            w_fetch_next   = burst_length;
                            w_deliver_next = burst_length;
                            w_state_next   = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_dequeue) begin
                        w_fetch_next = r_fetch_remaining - c_cnt_one;
                    end
                    if (w_transfer) begin
                        w_deliver_next = r_deliver_remaining - c_cnt_one;
                        if (r_deliver_remaining == c_cnt_one) begin
                            w_state_next = IDLE;
                            w_done_next  = 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    w_state_next = IDLE;
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state             <= IDLE;
            r_fetch_remaining   <= c_cnt_zero;
            r_deliver_remaining <= c_cnt_zero;
            r_fifo_flush        <= 1'b0;
            r_burst_done        <= 1'b0;
            r_busy              <= 1'b0;
        end else begin
            r_state             <= w_state_next;
            r_fetch_remaining   <= w_fetch_next;
            r_deliver_remaining <= w_deliver_next;
            r_fifo_flush        <= w_flush_next;
            r_burst_done        <= w_done_next;
            r_busy              <= (w_state_next != IDLE);
        end
    end

    assign fifo_dequeue = w_dequeue;
    assign fifo_flush   = r_fifo_flush;
    assign burst_done   = r_burst_done;
    assign busy         = r_busy;

endmodule : mixed_clock_fifo_reader
`default_nettype wire
